// File: rtl/frame_window_capture.sv
// Frame-aligned, decimated/windowed writer from the camera pixel stream into frame-buffer BRAM.
// One-cycle latency from accepted pixel to BRAM write; never stalls, so skipped or invalid pixels simply produce no write.
module frame_window_capture #(
    parameter int H_MAX  = 100,
    parameter int V_MAX  = 128,
    parameter int STRIDE = 120,
    parameter int DECIM  = 0,
    parameter int ADDR_W = 14
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              arm_in,
    input  logic              cont_in,
    input  logic              valid_in,
    input  logic [15:0]       data_in,
    input  logic [12:0]       hcount_in,
    input  logic [11:0]       vcount_in,
    output logic              fb_we_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [15:0]       fb_din_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              frame_pulse_out,
    output logic [14:0]       pix_count_out
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    localparam logic [12:0] H_LIM  = 13'(H_MAX);
    localparam logic [11:0] V_LIM  = 12'(V_MAX);
    localparam logic [12:0] H_MASK = 13'((1 << DECIM) - 1);
    localparam logic [11:0] V_MASK = 12'((1 << DECIM) - 1);

    state_t            state_q, state_d;
    logic              we_d, pulse_d;
    logic [14:0]       cnt_d;
    logic              sof, keep, in_win, wr_pix, row_over;
    logic [12:0]       col;
    logic [11:0]       row;
    logic [ADDR_W-1:0] addr_d;

    assign sof      = valid_in && (hcount_in == '0) && (vcount_in == '0);
    assign col      = hcount_in >> DECIM;
    assign row      = vcount_in >> DECIM;
    assign keep     = ((hcount_in & H_MASK) == '0) && ((vcount_in & V_MASK) == '0);
    assign in_win   = (col < H_LIM) && (row < V_LIM);
    assign wr_pix   = valid_in && keep && in_win;
    assign row_over = valid_in && (row >= V_LIM);
    // Modular arithmetic at ADDR_W bits equals the full-width product truncated to ADDR_W.
    assign addr_d   = ADDR_W'(row) * ADDR_W'(STRIDE) + ADDR_W'(col);

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        pulse_d = 1'b0;
        cnt_d   = pix_count_out;
        case (state_q)
            IDLE: begin
                if (arm_in) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (sof) begin
                    state_d = CAPTURE;
                    we_d    = 1'b1;
                    cnt_d   = 15'd1;
                end
            end
            CAPTURE: begin
                if (sof || row_over) begin
                    pulse_d = 1'b1;
                    if (!cont_in) begin
                        state_d = DONE;
                    end else if (sof) begin
                        // Continuous mode: the completing SOF opens the next frame.
                        we_d  = 1'b1;
                        cnt_d = 15'd1;
                    end else begin
                        state_d = WAIT_SOF;
                    end
                end else if (wr_pix) begin
                    we_d = 1'b1;
                    if (pix_count_out != 15'h7fff) cnt_d = pix_count_out + 15'd1;
                end
            end
            DONE: begin
                if (arm_in) state_d = WAIT_SOF;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q         <= IDLE;
            fb_we_out       <= 1'b0;
            fb_addr_out     <= '0;
            fb_din_out      <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            frame_pulse_out <= 1'b0;
            pix_count_out   <= '0;
        end else begin
            state_q         <= state_d;
            fb_we_out       <= we_d;
            frame_pulse_out <= pulse_d;
            pix_count_out   <= cnt_d;
            busy_out        <= (state_d == WAIT_SOF) || (state_d == CAPTURE);
            done_out        <= (state_d == DONE);
            if (we_d) begin
                fb_addr_out <= addr_d;
                fb_din_out  <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_frame_window_capture.sv
// Directed bench: one-shot, decimated, continuous, arm timing, mid-capture reset and gapped-valid scenarios.
module tb_frame_window_capture;

    logic        clk = 1'b0;
    logic        rst_n, cont, valid, arm0, arm1;
    logic [15:0] data;
    logic [12:0] hcount;
    logic [11:0] vcount;

    logic        fb_we0, busy0, done0, frame_pulse0;
    logic [13:0] fb_addr0;
    logic [15:0] fb_din0;
    logic [14:0] pix_count0;
    logic        fb_we1, busy1, done1, frame_pulse1;
    logic [13:0] fb_addr1;
    logic [15:0] fb_din1;
    logic [14:0] pix_count1;

    int checks = 0;
    int errors = 0;
    int wcnt0 = 0, wcnt1 = 0, pcnt0 = 0, pcnt1 = 0, bad0 = 0, bad1 = 0;
    int first0 = -1, last0 = -1, pulse_v0 = -1, pulse_h0 = -1;
    int first_seen0 = 0, saw243 = 0, ph = 0, pv = 0, w = 0;

    always #5 clk = ~clk;

    frame_window_capture dut0 (
        .clk_in(clk), .rst_in(rst_n), .arm_in(arm0), .cont_in(cont), .valid_in(valid),
        .data_in(data), .hcount_in(hcount), .vcount_in(vcount),
        .fb_we_out(fb_we0), .fb_addr_out(fb_addr0), .fb_din_out(fb_din0),
        .busy_out(busy0), .done_out(done0), .frame_pulse_out(frame_pulse0),
        .pix_count_out(pix_count0)
    );

    frame_window_capture #(.DECIM(1)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .arm_in(arm1), .cont_in(cont), .valid_in(valid),
        .data_in(data), .hcount_in(hcount), .vcount_in(vcount),
        .fb_we_out(fb_we1), .fb_addr_out(fb_addr1), .fb_din_out(fb_din1),
        .busy_out(busy1), .done_out(done1), .frame_pulse_out(frame_pulse1),
        .pix_count_out(pix_count1)
    );

    always @(posedge clk) begin
        ph = int'(hcount);
        pv = int'(vcount);
    end

    // Write monitors: data is {v,h} low bytes, so each address implies its expected data.
    always @(negedge clk) begin
        int a;
        logic [15:0] e;
        if (fb_we0) begin
            a = int'(fb_addr0);
            wcnt0++;
            last0 = a;
            if (first_seen0 == 0) begin
                first0 = a;
                first_seen0 = 1;
            end
            e = {8'(a / 120), 8'(a % 120)};
            if (fb_din0 !== e) bad0++;
        end
        if (frame_pulse0) begin
            pcnt0++;
            pulse_v0 = pv;
            pulse_h0 = ph;
        end
        if (fb_we1) begin
            a = int'(fb_addr1);
            wcnt1++;
            e = {8'(2 * (a / 120)), 8'(2 * (a % 120))};
            if (fb_din1 !== e) bad1++;
            if (a == 243 && fb_din1 === 16'h0406) saw243 = 1;
        end
        if (frame_pulse1) pcnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pix(input int h, input int v);
        valid  = 1'b1;
        hcount = 13'(h);
        vcount = 12'(v);
        data   = {8'(v), 8'(h)};
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_rows(input int wid, input int v_lo, input int v_hi);
        for (int v = v_lo; v < v_hi; v++)
            for (int h = 0; h < wid; h++)
                pix(h, v);
    endtask

    initial begin
        rst_n = 1'b0; cont = 1'b0; valid = 1'b0; arm0 = 1'b0; arm1 = 1'b0;
        data = '0; hcount = '0; vcount = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", fb_we0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pulse", frame_pulse0, 0);
        chk("rst_count", pix_count0, 0);
        chk("rst_addr", fb_addr0, 0);
        rst_n = 1'b1;
        idle();

        // arm coincident with SOF in IDLE: only arms
        arm0 = 1'b1;
        pix(0, 0);
        arm0 = 1'b0;
        chk("armsof_busy", busy0, 1);
        chk("armsof_we", fb_we0, 0);
        pix(1, 0);
        pix(2, 0);
        idle();
        chk("armsof_nowrites", wcnt0, 0);

        // one-shot 120x130 frame, arm pulse mid-capture ignored
        frame_rows(120, 0, 64);
        arm0 = 1'b1;
        idle();
        arm0 = 1'b0;
        chk("arm_in_capture_busy", busy0, 1);
        chk("arm_in_capture_done", done0, 0);
        frame_rows(120, 64, 128);
        pix(0, 128);
        chk("row128_pulse", frame_pulse0, 1);
        chk("row128_done", done0, 1);
        chk("row128_busy", busy0, 0);
        chk("row128_nowrite", fb_we0, 0);
        frame_rows(120, 129, 130);
        idle();
        chk("oneshot_writes", wcnt0, 12800);
        chk("oneshot_first", first0, 0);
        chk("oneshot_last", last0, 15339);
        chk("oneshot_pulses", pcnt0, 1);
        chk("oneshot_pulse_row", pulse_v0, 128);
        chk("oneshot_pulse_col", pulse_h0, 0);
        chk("oneshot_count", pix_count0, 12800);
        chk("oneshot_data", bad0, 0);
        frame_rows(120, 0, 130);
        idle();
        chk("frame2_writes", wcnt0, 12800);
        chk("frame2_pulses", pcnt0, 1);
        chk("frame2_done", done0, 1);
        chk("frame2_count", pix_count0, 12800);

        // DECIM=1 instance: 240-wide rows 0..9, closed by a SOF
        arm1 = 1'b1;
        idle();
        arm1 = 1'b0;
        chk("dec_busy", busy1, 1);
        frame_rows(240, 0, 10);
        pix(0, 0);
        chk("dec_pulse", frame_pulse1, 1);
        chk("dec_done", done1, 1);
        idle();
        chk("dec_writes", wcnt1, 500);
        chk("dec_count", pix_count1, 500);
        chk("dec_data", bad1, 0);
        chk("dec_pix_6_4", saw243, 1);
        chk("dec_pulses", pcnt1, 1);

        // continuous mode: 50x20 frame then SOF
        cont = 1'b1;
        arm0 = 1'b1;
        idle();
        arm0 = 1'b0;
        w = wcnt0;
        frame_rows(50, 0, 20);
        idle();
        chk("cont_count", pix_count0, 1000);
        chk("cont_writes", wcnt0 - w, 1000);
        pix(0, 0);
        chk("cont_sof_pulse", frame_pulse0, 1);
        chk("cont_sof_we", fb_we0, 1);
        chk("cont_sof_addr", fb_addr0, 0);
        chk("cont_sof_count", pix_count0, 1);
        chk("cont_sof_busy", busy0, 1);

        // gapped valid: one pixel every 4 cycles
        for (int i = 0; i < 3; i++) begin
            pix(5 + i, 3);
            chk("gap_we", fb_we0, 1);
            chk("gap_addr", fb_addr0, 365 + i);
            chk("gap_din", fb_din0, 3 * 256 + 5 + i);
            idle();
            chk("gap_we_low", fb_we0, 0);
            idle();
            idle();
        end
        chk("gap_count", pix_count0, 4);
        pix(110, 3);
        chk("outwin_we", fb_we0, 0);
        chk("outwin_count", pix_count0, 4);
        hcount = '0;
        vcount = '0;
        idle();
        chk("invalid_sof_pulse", frame_pulse0, 0);
        chk("invalid_sof_busy", busy0, 1);
        pix(0, 128);
        chk("cont_rowlim_pulse", frame_pulse0, 1);
        chk("cont_rowlim_busy", busy0, 1);
        chk("cont_rowlim_we", fb_we0, 0);
        chk("cont_rowlim_done", done0, 0);

        // reset in the middle of a capture
        frame_rows(50, 0, 10);
        chk("prerst_count", pix_count0, 500);
        pix(0, 10);
        chk("prerst_we", fb_we0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", fb_we0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_count", pix_count0, 0);
        chk("arst_addr", fb_addr0, 0);
        chk("arst_din", fb_din0, 0);
        chk("arst_done", done0, 0);
        chk("arst_pulse", frame_pulse0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cont = 1'b0;
        w = wcnt0;
        pix(0, 0);
        pix(1, 0);
        idle();
        chk("postrst_nowrites", wcnt0 - w, 0);
        chk("postrst_busy", busy0, 0);
        arm0 = 1'b1;
        idle();
        arm0 = 1'b0;
        pix(0, 0);
        chk("rearm_we", fb_we0, 1);
        chk("rearm_count", pix_count0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_window_capture.md
# frame_window_capture

Downstream stage of `camera_coord`. It takes the coordinate-tagged pixel stream (valid, RGB565 data, hcount, vcount) and writes a decimated, windowed image into the 15360-word frame-buffer BRAM. Capture is armed on request, aligned to the first pixel of a frame, and reported complete with a status level and pulse. It replaces the ad-hoc combinational `fb_addr`/`fb_we` logic in the top level with a registered, frame-aligned writer.

## Interface
Parameters:
- `H_MAX`, 100: window width, in decimated columns.
- `V_MAX`, 128: window height, in decimated rows.
- `STRIDE`, 120: BRAM words per row. Must satisfy `STRIDE >= H_MAX`.
- `DECIM`, 0: log2 decimation factor, range 0..3. 0 keeps every pixel.
- `ADDR_W`, 14: BRAM address width. Must satisfy `V_MAX*STRIDE <= 2**ADDR_W`.

Ports:
- `clk_in`  in  1  camera-domain clock.
- `rst_in`  in  1  reset. Asynchronous, active-low.
- `arm_in`  in  1  one-cycle request to capture a frame.
- `cont_in`  in  1  level. High selects continuous capture.
- `valid_in`  in  1  pixel strobe from `camera_coord`.
- `data_in`  in  16  pixel data.
- `hcount_in`  in  13  pixel column.
- `vcount_in`  in  12  pixel row.
- `fb_we_out`  out  1  BRAM write enable.
- `fb_addr_out`  out  ADDR_W  BRAM write address.
- `fb_din_out`  out  16  BRAM write data.
- `busy_out`  out  1  high in states WAIT_SOF and CAPTURE.
- `done_out`  out  1  high in state DONE.
- `frame_pulse_out`  out  1  one-cycle pulse on each capture completion.
- `pix_count_out`  out  15  number of words written in the current or last capture.

## Operation
- Definitions:
  - SOF pixel: `valid_in && hcount_in==0 && vcount_in==0`.
  - `col = hcount_in >> DECIM`, `row = vcount_in >> DECIM`.
  - Keep pixel: low DECIM bits of both `hcount_in` and `vcount_in` are zero.
  - In window: `col < H_MAX && row < V_MAX`.
  - Write pixel: keep pixel and in window.
- Write address: `row*STRIDE + col`, computed at full width and truncated to ADDR_W bits. Never exceeds `V_MAX*STRIDE-1`.
- FSM states: IDLE, WAIT_SOF, CAPTURE, DONE.
  - IDLE: `arm_in` -> WAIT_SOF.
  - WAIT_SOF: SOF pixel -> CAPTURE. That pixel is written and `pix_count_out` is set to 1.
  - CAPTURE: each write pixel writes one word and increments `pix_count_out`. Completion occurs on the first of:
    - a valid pixel with `row >= V_MAX`;
    - a SOF pixel.
  - On completion:
    - `frame_pulse_out` asserts for one cycle.
    - If `cont_in==0`: -> DONE. The completing pixel is not written.
    - If `cont_in==1` and the completion pixel is a SOF pixel: stay in CAPTURE, write the SOF pixel, and set `pix_count_out` to 1.
    - If `cont_in==1` and completion is by the row limit: -> WAIT_SOF.
  - DONE: `arm_in` -> WAIT_SOF. `pix_count_out` holds its value until the next SOF is captured.
- `arm_in` is ignored in WAIT_SOF and CAPTURE.
- `arm_in` coincident with a SOF pixel in IDLE or DONE: the FSM moves to WAIT_SOF only. That SOF is not captured.
- Writes occur only in CAPTURE, or on the SOF transition out of WAIT_SOF.
- `pix_count_out` saturates at 32767.

## Timing
- All outputs are registered.
- Latency: a write pixel at cycle N produces `fb_we_out=1` with its address and data at cycle N+1.
- `fb_we_out` is a single-cycle strobe per accepted pixel. Back-to-back `valid_in` gives back-to-back writes.
- `frame_pulse_out` asserts at N+1 for a completing pixel at N.
- `done_out` and `busy_out` reflect the state register. Both update at N+1.
- Reset values: all outputs 0, state IDLE. Assertion is asynchronous, and `fb_we_out` drops immediately even mid-capture. Release is used synchronously to `clk_in`.
- Non-keep pixels, out-of-window pixels, and pixels with `valid_in=0` produce no write. They do not stall the block.
- `data_in`, `hcount_in` and `vcount_in` are sampled only when `valid_in=1`.

## Test plan
- One-shot, DECIM=0, 120x130 frame: pulse `arm_in`, then stream two frames.
  - Exactly 12800 writes occur.
  - First write is at address 0.
  - Last write is at address 127*120+99=15339.
  - `frame_pulse_out` fires once, at the first pixel of row 128.
  - `done_out=1` afterwards and `pix_count_out=12800`.
  - The second frame produces no writes.
- DECIM=1, 240x260 frame:
  - Only even-row, even-column pixels are written.
  - Pixel (h=6, v=4) lands at address 2*120+3=243.
  - Total writes: 12800.
- Continuous mode: `cont_in=1`, stream a short 50x20 frame and a SOF.
  - The SOF ends the capture with `frame_pulse_out` and `pix_count_out=1000`.
  - The same SOF is written to address 0 and `pix_count_out` becomes 1.
- Arm timing:
  - `arm_in` on the same cycle as a SOF pixel in IDLE: no writes for that frame; capture starts on the next SOF.
  - `arm_in` during CAPTURE: no effect.
- Reset mid-capture: drive `rst_in` low at pixel 500. All outputs go to 0 asynchronously before the next edge. After release, no writes occur until re-armed.
- Gapped valid: `valid_in` high 1 cycle in 4 gives the same addresses and data as dense input. Each write appears exactly one cycle after its input.
